uart_packet_tx: RTL
===================

UART_PACKET_TX -- requirements
Module: uart_packet_tx

Interface
REQ-001 The module SHALL have: ipClk  input  1  system clock; all logic on rising edge.
REQ-002 The module SHALL have: ipReset  input  1  reset, synchronous and active-high.
REQ-003 The module SHALL have: ipTxPacket  input  UART_PACKET  packet stream (Valid, SoP, EoP, Length, Data, Source, Destination), one data byte per beat.
REQ-004 The module SHALL have: opTxReady  output  1  stream ready; a beat is accepted when ipTxPacket.Valid && opTxReady.
REQ-005 The module SHALL have: opByteData  output  8  serial byte to the UART transmitter.
REQ-006 The module SHALL have: opByteValid  output  1  opByteData valid; held with data stable until accepted.
REQ-007 The module SHALL have: ipByteReady  input  1  UART transmitter accepts byte when opByteValid && ipByteReady.
REQ-008 The module SHALL have: opBusy  output  1  high in every state except IDLE.
REQ-009 The module SHALL have: opError  output  1  one-cycle pulse per protocol error.

Function
REQ-010 The module SHALL serialise each packet as: 0x55, Destination, Source, Length, data bytes in order[, checksum].
REQ-011 States SHALL be IDLE, SYNC, DEST, SRC, LEN, DATA, FETCH, CSUM.
REQ-012 IDLE: opTxReady=1; an accepted beat with SoP=1 SHALL latch Destination, Source, Length, Data, EoP and go to SYNC next cycle.
REQ-013 IDLE: an accepted beat with SoP=0 SHALL be discarded and SHALL pulse opError the next cycle.
REQ-014 SYNC, DEST, SRC, LEN, DATA, CSUM SHALL drive opByteValid=1, opTxReady=0, and advance only on the cycle the byte is accepted.
REQ-015 SYNC->DEST->SRC->LEN->DATA on each byte acceptance.
REQ-016 DATA on acceptance: latched EoP=0 -> FETCH; EoP=1 -> CSUM (macro defined) or IDLE (macro undefined).
REQ-017 FETCH: opByteValid=0, opTxReady=1; an accepted beat SHALL latch Data/EoP and go to DATA next cycle.
REQ-018 FETCH: SoP=1 on an accepted beat SHALL be ignored as a flag (byte treated as data) and SHALL pulse opError.
REQ-019 An 8-bit data counter SHALL count data bytes sent; at EoP byte acceptance, count != latched Length (count modulo 256) SHALL pulse opError; the Length byte is still sent as latched.
REQ-020 Sustained throughput SHALL be one header byte per cycle and one data byte per two cycles with ipByteReady held high.
REQ-021 ipByteReady deasserted SHALL stall with opByteData and state unchanged, no byte lost or repeated.

Reset
REQ-022 ipReset SHALL force state IDLE, opByteValid=0, opByteData=0, opBusy=0, opError=0, counters and checksum 0; opTxReady=1 from the first cycle after reset.
REQ-023 Reset mid-packet SHALL abandon the packet without emitting further bytes; no opError.

Configuration
REQ-024 With UART_PACKET_TX_CHECKSUM_EN defined, CSUM SHALL emit one byte = 8-bit modulo-256 sum of Destination, Source, Length and all data bytes, then go to IDLE.
REQ-025 Without UART_PACKET_TX_CHECKSUM_EN, CSUM and checksum logic SHALL not exist; DATA with EoP goes to IDLE.

Structure
REQ-026 UART_PACKET stays in the shared Structures package; the sync constant 0x55 SHALL be added there as a named constant shared with the receive side.
REQ-027 The state enum SHALL be local to uart_packet_tx; no sub-module; the byte interface connects externally to the existing UART transmitter.

Verification
REQ-028 SoP beat {Dest=0x00, Src=0x01, Length=4, Data=0x01}, then beats 0x02, 0x03, 0x04(EoP), ipByteReady=1 -> bytes 55 00 01 04 01 02 03 04, opError never set; with macro, extra byte 0x0F.
REQ-029 Same packet, ipByteReady toggled 1-0-1 every cycle -> identical byte sequence, each byte held stable while unaccepted.
REQ-030 Single-beat packet SoP=EoP=1, Length=1, Data=0xAA -> 55 Dest Src 01 AA, return to IDLE, opBusy low next cycle (macro off).
REQ-031 SoP beat Length=3 with EoP on the 2nd data byte -> 2 data bytes sent, Length byte 0x03, one opError pulse.
REQ-032 Beat Valid=1, SoP=0 while IDLE -> no bytes emitted, one opError pulse, stays IDLE.
REQ-033 ipReset asserted during DATA of a 4-byte packet -> opByteValid=0 next cycle, opBusy=0, next SoP packet transmits correctly from 0x55.

Source files
------------

// File: rtl/uart_packet_tx_pkg.sv
// -----------------------------------------------------------------------------
// Structures -- shared packet types and constants for the UART packet path.
//
// Contents:
//   UART_PACKET     packet stream beat (Valid, SoP, EoP, Length, Data,
//                   Source, Destination), one data byte per beat.
//   UART_SYNC_BYTE  frame sync byte that opens every serialised packet; the
//                   receive side searches for the same value.
// -----------------------------------------------------------------------------
package Structures;

    typedef struct packed {
        logic       Valid;
        logic       SoP;
        logic       EoP;
        logic [7:0] Length;
        logic [7:0] Data;
        logic [7:0] Source;
        logic [7:0] Destination;
    } UART_PACKET;

    localparam logic [7:0] UART_SYNC_BYTE = 8'h55;

endpackage

// File: rtl/uart_packet_tx.sv
// -----------------------------------------------------------------------------
// uart_packet_tx -- serialises a packet stream into bytes for a UART transmitter.
//
// Frame on the byte interface: 0x55, Destination, Source, Length, data bytes,
// and, when UART_PACKET_TX_CHECKSUM_EN is defined, a trailing modulo-256 sum
// of Destination, Source, Length and all data bytes.
//
// Ports:
//   ipClk        in   system clock, rising edge
//   ipReset      in   synchronous active-high reset
//   ipTxPacket   in   UART_PACKET stream beat
//   opTxReady    out  stream ready; beat accepted on ipTxPacket.Valid && opTxReady
//   opByteData   out  byte to the UART transmitter
//   opByteValid  out  opByteData valid, held stable until accepted
//   ipByteReady  in   transmitter accepts byte on opByteValid && ipByteReady
//   opBusy       out  high whenever the FSM is not IDLE
//   opError      out  one-cycle pulse per protocol error
//   opState      out  current FSM state encoding, for observation
//
// Handshakes: both interfaces are valid/ready. A transfer happens on the
// rising edge where valid and ready are both high; the sender keeps valid and
// its payload unchanged until that edge.
//
// Build option: UART_PACKET_TX_CHECKSUM_EN adds the CSUM state and checksum.
// -----------------------------------------------------------------------------
module uart_packet_tx
    import Structures::*;
(
    input  logic       ipClk,
    input  logic       ipReset,
    input  UART_PACKET ipTxPacket,
    output logic       opTxReady,
    output logic [7:0] opByteData,
    output logic       opByteValid,
    input  logic       ipByteReady,
    output logic       opBusy,
    output logic       opError,
    output logic [2:0] opState
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        DEST  = 3'd2,
        SRC   = 3'd3,
        LEN   = 3'd4,
        DATA  = 3'd5,
        FETCH = 3'd6
`ifdef UART_PACKET_TX_CHECKSUM_EN
        ,
        CSUM  = 3'd7
`endif
    } tState;

    tState      state;
    logic [7:0] destReg;
    logic [7:0] srcReg;
    logic [7:0] lenReg;
    logic [7:0] dataReg;
    logic       eopReg;
    logic [7:0] dataCount;
`ifdef UART_PACKET_TX_CHECKSUM_EN
    logic [7:0] csum;
`endif

    logic beatTaken;
    logic byteTaken;

    assign beatTaken = ipTxPacket.Valid && opTxReady;
    assign byteTaken = opByteValid && ipByteReady;
    assign opState   = state;

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state       <= IDLE;
            opTxReady   <= 1'b1;
            opByteValid <= 1'b0;
            opByteData  <= 8'h00;
            opBusy      <= 1'b0;
            opError     <= 1'b0;
            destReg     <= 8'h00;
            srcReg      <= 8'h00;
            lenReg      <= 8'h00;
            dataReg     <= 8'h00;
            eopReg      <= 1'b0;
            dataCount   <= 8'h00;
`ifdef UART_PACKET_TX_CHECKSUM_EN
            csum        <= 8'h00;
`endif
        end else begin
            opError <= 1'b0;
            case (state)
                IDLE: begin
                    if (beatTaken) begin
                        if (ipTxPacket.SoP) begin
                            destReg     <= ipTxPacket.Destination;
                            srcReg      <= ipTxPacket.Source;
                            lenReg      <= ipTxPacket.Length;
                            dataReg     <= ipTxPacket.Data;
                            eopReg      <= ipTxPacket.EoP;
                            dataCount   <= 8'h00;
`ifdef UART_PACKET_TX_CHECKSUM_EN
                            csum        <= ipTxPacket.Destination + ipTxPacket.Source
                                         + ipTxPacket.Length;
`endif
                            state       <= SYNC;
                            opTxReady   <= 1'b0;
                            opByteValid <= 1'b1;
                            opByteData  <= UART_SYNC_BYTE;
                            opBusy      <= 1'b1;
                        end else begin
                            // Orphan beat outside a packet: drop it.
                            opError <= 1'b1;
                        end
                    end
                end
                SYNC: if (byteTaken) begin
                    state      <= DEST;
                    opByteData <= destReg;
                end
                DEST: if (byteTaken) begin
                    state      <= SRC;
                    opByteData <= srcReg;
                end
                SRC: if (byteTaken) begin
                    state      <= LEN;
                    opByteData <= lenReg;
                end
                LEN: if (byteTaken) begin
                    state      <= DATA;
                    opByteData <= dataReg;
                end
                DATA: begin
                    if (byteTaken) begin
                        dataCount <= dataCount + 8'd1;
`ifdef UART_PACKET_TX_CHECKSUM_EN
                        csum      <= csum + opByteData;
`endif
                        if (eopReg) begin
                            // Count includes the byte being accepted now.
                            if (dataCount + 8'd1 != lenReg)
                                opError <= 1'b1;
`ifdef UART_PACKET_TX_CHECKSUM_EN
                            state      <= CSUM;
                            opByteData <= csum + opByteData;
`else
                            state       <= IDLE;
                            opByteValid <= 1'b0;
                            opTxReady   <= 1'b1;
                            opBusy      <= 1'b0;
`endif
                        end else begin
                            state       <= FETCH;
                            opByteValid <= 1'b0;
                            opTxReady   <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (beatTaken) begin
                        // A stray SoP mid-packet is flagged but the byte is kept as data.
                        if (ipTxPacket.SoP)
                            opError <= 1'b1;
                        eopReg      <= ipTxPacket.EoP;
                        state       <= DATA;
                        opByteValid <= 1'b1;
                        opByteData  <= ipTxPacket.Data;
                        opTxReady   <= 1'b0;
                    end
                end
`ifdef UART_PACKET_TX_CHECKSUM_EN
                CSUM: if (byteTaken) begin
                    state       <= IDLE;
                    opByteValid <= 1'b0;
                    opTxReady   <= 1'b1;
                    opBusy      <= 1'b0;
                end
`endif
                default: begin
                    state       <= IDLE;
                    opByteValid <= 1'b0;
                    opTxReady   <= 1'b1;
                    opBusy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
